// File: rtl/seg7_scroll_ctrl_if.sv
// Write port of the scroll controller message buffer.
// Carries one nibble per accepted valid/ready transfer.
interface seg7_scroll_ctrl_if;
  logic       IN_WR_VALID;
  logic [3:0] IN_WR_DATA;
  logic       OUT_WR_READY;

  modport master (
    output IN_WR_VALID,
    output IN_WR_DATA,
    input  OUT_WR_READY
  );

  modport slave (
    input  IN_WR_VALID,
    input  IN_WR_DATA,
    output OUT_WR_READY
  );
endinterface

// File: rtl/seg7_scroll_ctrl.sv
// Scroll sequencer feeding the segment7 digit inputs D1..D4.
// Buffers a nibble message and rotates it across the digits.
module seg7_scroll_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int DEPTH    = 8
) (
  input  logic       CLK,
  input  logic       IN_RST,
  seg7_scroll_ctrl_if.slave wr,
  input  logic       IN_START,
  input  logic       IN_STOP,
  input  logic       IN_FLUSH,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic [3:0] D4,
  output logic       OUT_BUSY,
  output logic       OUT_WRAP
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = CW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [PW-1:0] pos, pos_n;
  logic [TW-1:0] tick;
  logic [3:0]    mem [DEPTH];

  logic          wr_fire;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] pos_inc;
  logic          tick_hit;
  logic          load, adv;
  logic [CW-1:0] eff_cnt;
  logic [PW-1:0] base;
  logic [IW-1:0] idx;
  logic [3:0]    win [4];

  assign wr.OUT_WR_READY = (state == IDLE) && (count < CW'(DEPTH));
  assign OUT_BUSY = (state == RUN);

  assign wr_fire  = wr.IN_WR_VALID && wr.OUT_WR_READY;
  assign wr_idx   = IN_FLUSH ? '0 : count;
  assign tick_hit = (tick == TW'(TICK_DIV - 1));
  assign pos_inc  = CW'(pos) + CW'(1);
  assign pos_n    = (pos_inc >= count) ? '0 : PW'(pos_inc);

  always_comb begin
    state_n = state;
    count_n = count;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (IN_FLUSH) count_n = '0;
        if (wr_fire)  count_n = wr_idx + CW'(1);
        if (!IN_FLUSH && IN_START && count_n != '0) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (IN_STOP)       state_n = IDLE;
        else if (tick_hit) adv = 1'b1;
      end
    endcase
  end

  // Window read folds in a same-cycle write so START+write sees it.
  always_comb begin
    eff_cnt = load ? count_n : count;
    base    = load ? '0 : pos_n;
    idx     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = IW'(base) + IW'(k);
      for (int j = 0; j < 3; j++)
        if (idx >= IW'(eff_cnt)) idx = idx - IW'(eff_cnt);
      win[k] = (wr_fire && idx == IW'(wr_idx))
             ? wr.IN_WR_DATA : mem[idx[PW-1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (!IN_RST && wr_fire)
      mem[wr_idx[PW-1:0]] <= wr.IN_WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (IN_RST) begin
      state    <= IDLE;
      count    <= '0;
      pos      <= '0;
      tick     <= '0;
      D1       <= '0;
      D2       <= '0;
      D3       <= '0;
      D4       <= '0;
      OUT_WRAP <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      OUT_WRAP <= adv && (pos_n == '0);
      if (load) begin
        pos  <= '0;
        tick <= '0;
      end else if (state == RUN && !IN_STOP) begin
        if (adv) begin
          tick <= '0;
          pos  <= pos_n;
        end else begin
          tick <= tick + TW'(1);
        end
      end
      if (load || adv) begin
        D1 <= win[0];
        D2 <= win[1];
        D3 <= win[2];
        D4 <= win[3];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Directed vector bench for seg7_scroll_ctrl.
// TICK_DIV=4, DEPTH=8; expected digits packed as {D1,D2,D3,D4}.
module tb_seg7_scroll_ctrl;

  logic       CLK = 1'b0;
  logic       IN_RST = 1'b0;
  logic       IN_START = 1'b0;
  logic       IN_STOP = 1'b0;
  logic       IN_FLUSH = 1'b0;
  logic [3:0] D1, D2, D3, D4;
  logic       OUT_BUSY, OUT_WRAP;

  seg7_scroll_ctrl_if wr();

  seg7_scroll_ctrl #(
    .TICK_DIV(4),
    .DEPTH(8)
  ) dut (
    .CLK(CLK),
    .IN_RST(IN_RST),
    .wr(wr),
    .IN_START(IN_START),
    .IN_STOP(IN_STOP),
    .IN_FLUSH(IN_FLUSH),
    .D1(D1),
    .D2(D2),
    .D3(D3),
    .D4(D4),
    .OUT_BUSY(OUT_BUSY),
    .OUT_WRAP(OUT_WRAP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic [3:0]  dat;
    logic        start;
    logic        stop;
    logic        flush;
    logic [15:0] d;
    logic        busy;
    logic        wrap;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  logic [3:0]  msg1   [6] = '{4'h1, 4'hF, 4'hA, 4'h5, 4'h8, 4'h0};
  logic [15:0] steps1 [6] = '{16'hFA58, 16'hA580, 16'h5801,
                              16'h801F, 16'h01FA, 16'h1FA5};
  logic [3:0]  msg2   [8] = '{4'h2, 4'h3, 4'h4, 4'h5,
                              4'h6, 4'h7, 4'h8, 4'hE};
  logic [15:0] steps2 [4] = '{16'h3456, 16'h4567, 16'h5678, 16'h678E};

  task automatic add(input string n, input logic rst, input logic vld,
                     input logic [3:0] dat, input logic start,
                     input logic stop, input logic flush,
                     input logic [15:0] d, input logic busy,
                     input logic wrap, input logic rdy);
    vec_t v;
    v.name = n;  v.rst = rst;     v.vld = vld;   v.dat = dat;
    v.start = start; v.stop = stop; v.flush = flush;
    v.d = d;     v.busy = busy;   v.wrap = wrap; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic idle(input string n, input int k, input logic [15:0] d,
                      input logic busy, input logic rdy);
    repeat (k) add(n, 0, 0, 4'h0, 0, 0, 0, d, busy, 0, rdy);
  endtask

  task automatic apply(input vec_t v, input int i);
    logic [15:0] got;
    @(negedge CLK);
    IN_RST         = v.rst;
    wr.IN_WR_VALID = v.vld;
    wr.IN_WR_DATA  = v.dat;
    IN_START       = v.start;
    IN_STOP        = v.stop;
    IN_FLUSH       = v.flush;
    @(posedge CLK);
    #1;
    got = {D1, D2, D3, D4};
    checks++;
    if (got !== v.d || OUT_BUSY !== v.busy ||
        OUT_WRAP !== v.wrap || wr.OUT_WR_READY !== v.rdy) begin
      failures++;
      $display("FAIL %s[%0d]: got d=%h busy=%b wrap=%b rdy=%b want d=%h busy=%b wrap=%b rdy=%b",
               v.name, i, got, OUT_BUSY, OUT_WRAP, wr.OUT_WR_READY,
               v.d, v.busy, v.wrap, v.rdy);
    end
  endtask

  initial begin
    logic [15:0] prev;
    wr.IN_WR_VALID = 1'b0;
    wr.IN_WR_DATA  = 4'h0;

    // scroll a 6-nibble message through a full rotation
    add("rst", 1, 0, 4'h0, 0, 0, 0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      add("wr1", 0, 1, msg1[i], 0, 0, 0, 16'h0000, 0, 0, 1);
    add("start1", 0, 0, 4'h0, 1, 0, 0, 16'h1FA5, 1, 0, 0);
    prev = 16'h1FA5;
    for (int i = 0; i < 6; i++) begin
      idle("run1", 3, prev, 1, 0);
      add("step1", 0, 0, 4'h0, 0, 0, 0, steps1[i], 1, (i == 5), 0);
      prev = steps1[i];
    end
    add("stop1", 0, 0, 4'h0, 0, 1, 0, 16'h1FA5, 0, 0, 1);

    // fill to DEPTH, then writes against a full buffer
    add("flush2", 0, 0, 4'h0, 0, 0, 1, 16'h1FA5, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      add("wr2", 0, 1, msg2[i], 0, 0, 0, 16'h1FA5, 0, 0, (i < 7));
    for (int i = 0; i < 3; i++)
      add("full2", 0, 1, 4'h9, 0, 0, 0, 16'h1FA5, 0, 0, 0);
    add("start2", 0, 0, 4'h0, 1, 0, 0, 16'h2345, 1, 0, 0);
    prev = 16'h2345;
    for (int i = 0; i < 4; i++) begin
      idle("run2", 3, prev, 1, 0);
      add("step2", 0, 0, 4'h0, 0, 0, 0, steps2[i], 1, 0, 0);
      prev = steps2[i];
    end
    add("stop2", 0, 0, 4'h0, 0, 1, 0, 16'h678E, 0, 0, 0);

    // single nibble: every step wraps; flush+write same cycle
    add("flush3", 0, 0, 4'h0, 0, 0, 1, 16'h678E, 0, 0, 1);
    add("wr3", 0, 1, 4'h7, 0, 0, 0, 16'h678E, 0, 0, 1);
    add("start3", 0, 0, 4'h0, 1, 0, 0, 16'h7777, 1, 0, 0);
    for (int r = 0; r < 2; r++) begin
      idle("run3", 3, 16'h7777, 1, 0);
      add("wrap3", 0, 0, 4'h0, 0, 0, 0, 16'h7777, 1, 1, 0);
    end
    add("stop3", 0, 0, 4'h0, 0, 1, 0, 16'h7777, 0, 0, 1);
    add("flwr3", 0, 1, 4'h3, 0, 0, 1, 16'h7777, 0, 0, 1);
    add("start3b", 0, 0, 4'h0, 1, 0, 0, 16'h3333, 1, 0, 0);
    idle("run3b", 3, 16'h3333, 1, 0);
    add("stoptick3", 0, 0, 4'h0, 0, 1, 0, 16'h3333, 0, 0, 1);

    // stop on tick, append, restart at pos 0
    add("flwr4", 0, 1, 4'h1, 0, 0, 1, 16'h3333, 0, 0, 1);
    add("wr4", 0, 1, 4'h2, 0, 0, 0, 16'h3333, 0, 0, 1);
    add("wr4", 0, 1, 4'h3, 0, 0, 0, 16'h3333, 0, 0, 1);
    add("start4", 0, 0, 4'h0, 1, 0, 0, 16'h1231, 1, 0, 0);
    idle("run4", 3, 16'h1231, 1, 0);
    add("stoptick4", 0, 0, 4'h0, 0, 1, 0, 16'h1231, 0, 0, 1);
    add("append4", 0, 1, 4'h6, 0, 0, 0, 16'h1231, 0, 0, 1);
    add("restart4", 0, 0, 4'h0, 1, 0, 0, 16'h1236, 1, 0, 0);
    idle("run4b", 3, 16'h1236, 1, 0);
    add("step4", 0, 0, 4'h0, 0, 0, 0, 16'h2361, 1, 0, 0);
    add("stop4", 0, 0, 4'h0, 0, 1, 0, 16'h2361, 0, 0, 1);

    // start on empty buffer, then start with same-cycle write
    add("flush5", 0, 0, 4'h0, 0, 0, 1, 16'h2361, 0, 0, 1);
    add("stempty5", 0, 0, 4'h0, 1, 0, 0, 16'h2361, 0, 0, 1);
    idle("idle5", 1, 16'h2361, 0, 1);
    add("stwr5", 0, 1, 4'h2, 1, 0, 0, 16'h2222, 1, 0, 0);

    // reset mid-run with other inputs active
    idle("run6", 2, 16'h2222, 1, 0);
    add("rst6", 1, 1, 4'h5, 1, 1, 0, 16'h0000, 0, 0, 1);
    add("rst6", 1, 1, 4'h5, 1, 1, 0, 16'h0000, 0, 0, 1);
    add("stempty6", 0, 0, 4'h0, 1, 0, 0, 16'h0000, 0, 0, 1);
    add("stwr6", 0, 1, 4'h9, 1, 0, 0, 16'h9999, 1, 0, 0);
    idle("run6b", 3, 16'h9999, 1, 0);
    add("wrap6", 0, 0, 4'h0, 0, 0, 0, 16'h9999, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scroll_ctrl.md
Name: seg7_scroll_ctrl

Overview:
- Sequencer that sits in front of the `segment7` display datapath and drives its `D1`–`D4` digit inputs.
- Buffers a message of up to `DEPTH` hex nibbles through a valid/ready write port.
- On command, scrolls the message across the four digits, advancing one position every `TICK_DIV` clocks, with wrap-around.
- Replaces hand-driven `D1`–`D4` stimulus with a controlled content source.

Parameters:
- `TICK_DIV`, 50000000: clocks per scroll step (≥2).
- `DEPTH`, 8: message buffer capacity in nibbles (4..15).

Ports:
- `CLK`, in, 1: system clock, rising edge.
- `IN_RST`, in, 1: synchronous active-high reset.
- `IN_WR_VALID`, in, 1: write request.
- `IN_WR_DATA`, in, 4: nibble to append.
- `OUT_WR_READY`, out, 1: buffer accepts a write this cycle.
- `IN_START`, in, 1: begin scrolling (level-sampled, one cycle suffices).
- `IN_STOP`, in, 1: halt scrolling, freeze display.
- `IN_FLUSH`, in, 1: empty the buffer.
- `D1`, out, 4: digit 1 nibble, to `segment7`.
- `D2`, out, 4: digit 2 nibble.
- `D3`, out, 4: digit 3 nibble.
- `D4`, out, 4: digit 4 nibble.
- `OUT_BUSY`, out, 1: high in RUN.
- `OUT_WRAP`, out, 1: one-cycle pulse when the scroll position returns to 0.

Behaviour:

Reset and handshake
- Reset (`IN_RST`=1 at an edge): state=IDLE, count=0, pos=0, tick counter=0, `D1`–`D4`=0, `OUT_BUSY`=0, `OUT_WRAP`=0. Buffer contents are don't-care.
- Reset mid-RUN aborts immediately, with the same values as above.
- `OUT_WR_READY` = (state==IDLE) && (count<`DEPTH`). It is combinational from registered state.
- A write is accepted when `IN_WR_VALID` && `OUT_WR_READY`: buf[count] <= data, count <= count+1.
- When count==`DEPTH`, ready=0; valid is ignored with no overwrite and no error.

State IDLE
- Accepts writes.
- `D1`–`D4` hold their last value.
- Priority within a cycle: FLUSH > START; writes are independent.
- `IN_FLUSH`: count <= 0. If a write is accepted in the same cycle, it lands at buf[0] and count <= 1.
- `IN_START` with effective count ≥1 → RUN. Effective count includes a write accepted in the same cycle.
- `IN_START` with effective count 0 is ignored; state stays IDLE.
- On entry to RUN: pos <= 0, tick counter <= 0, and on that same edge the window is loaded: `D1`=buf[0], `D2`=buf[1 mod count], `D3`=buf[2 mod count], `D4`=buf[3 mod count].

State RUN
- `OUT_BUSY`=1, `OUT_WR_READY`=0.
- `IN_FLUSH` is ignored.
- Tick counter increments every cycle.
- When it equals `TICK_DIV`-1: counter <= 0, pos <= (pos+1) mod count, and the window is updated on the same edge: `Dk` = buf[(pos'+k-1) mod count].
- First advance occurs `TICK_DIV` cycles after RUN entry.
- `OUT_WRAP` is registered and high for exactly the one cycle following an advance where pos' == 0.
- With count==1, every step wraps; `OUT_WRAP` pulses every `TICK_DIV` cycles.
- `IN_STOP` → IDLE next edge. pos and counter are not advanced even if a tick coincides. `D1`–`D4` freeze. `OUT_WRAP` is not asserted. Buffer and count are retained.
- `IN_START` in RUN is ignored.

Arithmetic and boundaries
- mod is true modulo over count ∈ 1..`DEPTH`, so count<4 repeats nibbles.
- pos width is ceil(log2 `DEPTH`).
- Tick counter width is ceil(log2 `TICK_DIV`).
- STOP then START restarts at pos 0, not at the frozen pos.
- Writes after STOP append to the retained message.

Test Plan (`TICK_DIV`=4, `DEPTH`=8):
1. Reset, then write 1, F, A, 5, 8, 0 → count=6 and ready stays 1. START → next edge `D1`–`D4`=1,F,A,5. Advances occur 4 cycles later, and every 4 after that: F,A,5,8 → A,5,8,0 → 5,8,0,1 → 8,0,1,F → 0,1,F,A → 1,F,A,5. `OUT_WRAP` pulses once at the 6th step.
2. Write 8 nibbles → ready=0 after the 8th. Then hold valid with 9 for 3 cycles → no change; buf[7] is intact.
3. Flush, write only 7, START → `D1`–`D4`=7,7,7,7 and `OUT_WRAP` pulses every 4 cycles. Flush plus write 3 in the same cycle → count=1, buf[0]=3.
4. In RUN, assert STOP on the tick cycle → state IDLE, digits unchanged, no `OUT_WRAP`. Write 6 → count+1. START → window restarts at buf[0].
5. START with count=0 → stays IDLE, `OUT_BUSY`=0. START plus write 2 in the same cycle → RUN with `D1`–`D4`=2,2,2,2.
6. Assert `IN_RST` mid-RUN → next edge: all `D`=0, `OUT_BUSY`=0, ready=1, count=0. `IN_WR_VALID`, `IN_START` and `IN_STOP` during reset are ignored.
